// File: rtl/ipg_msg_engine_if.sv
// Bundles the RX chunk stream, the memq reply channel and the memory write strobe of ipg_msg_engine.
// master = surrounding fabric (RX extractor / memq / memory), slave = the engine.
interface ipg_msg_engine_if #(
    parameter int DATA_W    = 64,
    parameter int ADR_W     = 128,
    parameter int PAYLOAD_W = 512,
    parameter int LEN_W     = $clog2(DATA_W) + 1
);
    logic [DATA_W-1:0]    rx_ipg_data;
    logic [LEN_W-1:0]     rx_len;
    logic                 rx_valid;
    logic                 rx_full;
    logic                 rx_drop;
    logic [DATA_W-1:0]    memq_data;
    logic                 memq_valid;
    logic                 memq_ready;
    logic                 mem_wr_valid;
    logic [ADR_W/2-1:0]   mem_wr_addr;
    logic [PAYLOAD_W-1:0] mem_wr_data;

    modport master (
        output rx_ipg_data, rx_len, rx_valid, memq_ready,
        input  rx_full, rx_drop, memq_data, memq_valid, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  rx_ipg_data, rx_len, rx_valid, memq_ready,
        output rx_full, rx_drop, memq_data, memq_valid, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/ipg_msg_engine.sv
// IPG memory-message engine: queues RX bit-chunks, reassembles {header, src|dst, payload}
// messages, answers reads with framed reply chunks and issues writes as a one-cycle strobe.
module ipg_msg_engine #(
    parameter int DATA_W     = 64,
    parameter int HDR_W      = 16,
    parameter int ADR_W      = 128,
    parameter int PAYLOAD_W  = 512,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = $clog2(DATA_W) + 1
) (
    input  logic                clk,
    input  logic                reset,
    ipg_msg_engine_if.slave     bus,
    output logic                busy,
    output logic [15:0]         err_cnt
);
    localparam int HALF_W   = ADR_W / 2;
    localparam int MSG_W    = HDR_W + ADR_W + PAYLOAD_W;
    localparam int RD_LEN   = HDR_W + ADR_W;
    localparam int CNT_W    = $clog2(MSG_W + DATA_W + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CHUNK_W  = DATA_W - 8;
    localparam int REPLY_W  = HDR_W + PAYLOAD_W;
    localparam int N_CHUNKS = (REPLY_W + CHUNK_W - 1) / CHUNK_W;
    localparam int SR_W     = N_CHUNKS * CHUNK_W;
    localparam int CHK_W    = $clog2(N_CHUNKS + 1);
    localparam int REP      = PAYLOAD_W / HALF_W;

    typedef enum logic [1:0] {COLLECT, CHECK, REPLY, WRITE} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [LEN_W-1:0]     fifo_len  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       fifo_cnt;
    logic [LEN_W-1:0]     push_len;
    logic [DATA_W-1:0]    push_data;
    logic                 push_req, push, pop;
    logic [MSG_W-1:0]     msg, placed, merged;
    logic [CNT_W-1:0]     bit_cnt, sum_cnt, target;
    logic [1:0]           new_op;
    logic [HDR_W-1:0]     cur_hdr;
    logic [HALF_W-1:0]    src, dst;
    logic [SR_W-1:0]      reply_sr, reply_init;
    logic [CHK_W-1:0]     chunk_idx;
    logic                 hdr_bad, msg_done, same_addr, is_read;

    // Stored chunks are clamped and stripped of bits below rx_len so they can be OR-merged directly.
    assign push_len  = (bus.rx_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.rx_len;
    assign push_data = bus.rx_ipg_data & ~({DATA_W{1'b1}} >> push_len);
    assign push_req  = bus.rx_valid && (bus.rx_len != '0);
    assign bus.rx_full = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign push      = push_req && !bus.rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            bus.rx_drop <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_len[i]  <= '0;
            end
        end else begin
            bus.rx_drop <= push_req && bus.rx_full;
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_len[wr_ptr]  <= push_len;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // The message is built MSB-aligned, so the header always sits at the top of msg.
    assign placed  = {fifo_data[rd_ptr], {(MSG_W-DATA_W){1'b0}}} >> bit_cnt;
    assign merged  = msg | placed;
    assign sum_cnt = bit_cnt + CNT_W'(fifo_len[rd_ptr]);
    assign new_op  = merged[MSG_W-1 -: 2];
    assign target  = (new_op == 2'b01) ? CNT_W'(RD_LEN) : CNT_W'(MSG_W);

    assign cur_hdr = msg[MSG_W-1 -: HDR_W];
    assign src     = msg[MSG_W-HDR_W-1 -: HALF_W];
    assign dst     = msg[MSG_W-HDR_W-HALF_W-1 -: HALF_W];
    assign is_read = (cur_hdr[HDR_W-1 -: 2] == 2'b01);
    assign reply_init = ({SR_W{1'b1}} >> REPLY_W)
                      | (SR_W'({2'b11, cur_hdr[HDR_W-3:0], {REP{dst}}}) << (SR_W - REPLY_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        hdr_bad   = 1'b0;
        msg_done  = 1'b0;
        same_addr = 1'b0;
        case (state_q)
            COLLECT: begin
                if (fifo_cnt != '0) begin
                    pop = 1'b1;
                    if (sum_cnt >= CNT_W'(HDR_W)) begin
                        if (new_op == 2'b00 || new_op == 2'b11) begin
                            hdr_bad = 1'b1;
                        end else if (sum_cnt >= target) begin
                            msg_done = 1'b1;
                            state_d  = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (src == dst) begin
                    same_addr = 1'b1;
                    state_d   = COLLECT;
                end else begin
                    state_d = is_read ? REPLY : WRITE;
                end
            end
            REPLY: begin
                if (bus.memq_ready && chunk_idx == CHK_W'(N_CHUNKS - 1)) state_d = COLLECT;
            end
            WRITE: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg       <= '0;
            bit_cnt   <= '0;
            reply_sr  <= '0;
            chunk_idx <= '0;
            err_cnt   <= '0;
        end else begin
            if ((hdr_bad || same_addr) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            case (state_q)
                COLLECT: begin
                    if (hdr_bad) begin
                        msg     <= '0;
                        bit_cnt <= '0;
                    end else if (pop) begin
                        msg     <= merged;
                        bit_cnt <= msg_done ? target : sum_cnt;
                    end
                end
                CHECK: begin
                    reply_sr  <= reply_init;
                    chunk_idx <= '0;
                    if (same_addr || is_read) begin
                        msg     <= '0;
                        bit_cnt <= '0;
                    end
                end
                REPLY: begin
                    if (bus.memq_ready) begin
                        reply_sr  <= reply_sr << CHUNK_W;
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                WRITE: begin
                    msg     <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.memq_valid   = (state_q == REPLY);
    assign bus.memq_data    = bus.memq_valid ? {reply_sr[SR_W-1 -: CHUNK_W], 8'h1e} : '0;
    assign bus.mem_wr_valid = (state_q == WRITE);
    assign bus.mem_wr_addr  = bus.mem_wr_valid ? dst : '0;
    assign bus.mem_wr_data  = bus.mem_wr_valid ? msg[PAYLOAD_W-1:0] : '0;
    assign busy             = (state_q != COLLECT) || (bit_cnt != '0);
endmodule

// File: tb/tb_ipg_msg_engine.sv
// Randomised scoreboard bench for ipg_msg_engine: messages are described at field level,
// expected replies/writes are queued on issue and a monitor retires them as the DUT emits them.
module tb_ipg_msg_engine;
    localparam int DATA_W     = 64;
    localparam int HDR_W      = 16;
    localparam int PAYLOAD_W  = 512;
    localparam int FIFO_DEPTH = 8;
    localparam int CHUNK_W    = DATA_W - 8;
    localparam int N_CHUNKS   = (HDR_W + PAYLOAD_W + CHUNK_W - 1) / CHUNK_W;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] err_cnt;

    ipg_msg_engine_if bus();

    ipg_msg_engine dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             expErr = 0;
    int             dropCount = 0;
    int             hsCount = 0;
    int             wrCount = 0;
    int             readyMode = 3;
    int             chunkNo = 0;
    bit             monEn = 1'b0;
    bit             prevStall = 1'b0;
    logic [63:0]    prevData = '0;
    logic [63:0]    firstChunk = '0;
    logic [63:0]    lastChunk = '0;
    logic [63:0]    expQ[$];
    logic [63:0]    wrAddrQ[$];
    logic [511:0]   wrDataQ[$];

    task automatic checkOutput(input string name, input logic [575:0] actual, input logic [575:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [6:0] len);
        int guard;
        guard = 0;
        while (bus.rx_full && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_full_wait actual=stuck_full required=space");
        end
        bus.rx_ipg_data = data;
        bus.rx_len      = len;
        bus.rx_valid    = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_len   = '0;
        if ($urandom_range(0, 3) == 0) begin
            bus.rx_valid = 1'(($urandom_range(0, 1)));
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    // Reference model: message fields -> expected reply chunks / write / error, then chunked RX.
    task automatic sendMessage(input logic [15:0] hdr, input logic [63:0] src, input logic [63:0] dst,
                               input logic [511:0] pay, input int fixedLen);
        bit          bits[$];
        bit          rb[$];
        logic [63:0] chunk, data;
        int          len, take, rxl;
        for (int i = 15; i >= 0; i--) bits.push_back(hdr[i]);
        if (hdr[15:14] == 2'b01 || hdr[15:14] == 2'b10) begin
            for (int i = 63; i >= 0; i--) bits.push_back(src[i]);
            for (int i = 63; i >= 0; i--) bits.push_back(dst[i]);
            if (hdr[15:14] == 2'b10)
                for (int i = 511; i >= 0; i--) bits.push_back(pay[i]);
            if (src == dst) begin
                expErr++;
            end else if (hdr[15:14] == 2'b10) begin
                wrAddrQ.push_back(dst);
                wrDataQ.push_back(pay);
            end else begin
                rb.push_back(1'b1);
                rb.push_back(1'b1);
                for (int i = 13; i >= 0; i--) rb.push_back(hdr[i]);
                for (int r = 0; r < PAYLOAD_W / 64; r++)
                    for (int i = 63; i >= 0; i--) rb.push_back(dst[i]);
                while (rb.size() < N_CHUNKS * CHUNK_W) rb.push_back(1'b1);
                for (int c = 0; c < N_CHUNKS; c++) begin
                    chunk = 64'h1e;
                    for (int b = 63; b >= 8; b--) chunk[b] = rb.pop_front();
                    expQ.push_back(chunk);
                end
            end
        end else begin
            expErr++;
        end
        while (bits.size() > 0) begin
            len = (fixedLen > 0) ? fixedLen : int'($urandom_range(1, 64));
            if (len >= bits.size()) begin
                take = bits.size();
                len  = (fixedLen > 0) ? take : int'($urandom_range(take, 64));
            end else begin
                take = len;
            end
            data = {$urandom, $urandom};
            for (int b = 0; b < take; b++) data[63-b] = bits.pop_front();
            rxl = len;
            if (len == 64 && $urandom_range(0, 3) == 0) rxl = $urandom_range(65, 127);
            applyStimulus(data, 7'(rxl));
        end
    endtask

    task automatic drain();
        int quiet, cyc;
        quiet = 0;
        cyc   = 0;
        while (quiet < 12 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!busy && expQ.size() == 0 && wrAddrQ.size() == 0) quiet++;
            else quiet = 0;
        end
        if (cyc >= 5000) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=pending=%0d/%0d required=0", expQ.size(), wrAddrQ.size());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       bus.memq_ready = 1'b0;
                1:       bus.memq_ready = ~bus.memq_ready;
                2:       bus.memq_ready = 1'(($urandom_range(0, 1)));
                default: bus.memq_ready = 1'b1;
            endcase
        end
    end

    // Monitor: retires scoreboard entries on every reply handshake and write strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!monEn) begin
                prevStall = 1'b0;
                chunkNo   = 0;
            end else begin
                if (prevStall)
                    checkOutput("memq_hold", {bus.memq_valid, bus.memq_data}, {1'b1, prevData});
                if (bus.memq_valid && bus.memq_ready) begin
                    hsCount++;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL memq_unexpected actual=%0h required=no_output", bus.memq_data);
                    end else begin
                        checkOutput("memq_chunk", bus.memq_data, expQ.pop_front());
                    end
                    if (chunkNo == 0) firstChunk = bus.memq_data;
                    if (chunkNo == N_CHUNKS - 1) lastChunk = bus.memq_data;
                    chunkNo = (chunkNo + 1) % N_CHUNKS;
                end
                if (bus.mem_wr_valid) begin
                    wrCount++;
                    if (wrAddrQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL mem_wr_unexpected actual=%0h required=no_write", bus.mem_wr_addr);
                    end else begin
                        checkOutput("mem_wr_addr", bus.mem_wr_addr, wrAddrQ.pop_front());
                        checkOutput("mem_wr_data", bus.mem_wr_data, wrDataQ.pop_front());
                    end
                end
                if (bus.rx_drop) dropCount++;
                prevStall = bus.memq_valid && !bus.memq_ready;
                prevData  = bus.memq_data;
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0]  hdr;
        logic [63:0]  s, d;
        logic [511:0] p;
        int           sel, hsBefore, wrBefore, dropsBefore, guard;

        bus.rx_ipg_data = '0;
        bus.rx_len      = '0;
        bus.rx_valid    = 1'b0;
        bus.memq_ready  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_memq_valid", bus.memq_valid, 1'b0);
        checkOutput("reset_memq_data", bus.memq_data, 64'h0);
        checkOutput("reset_mem_wr_valid", bus.mem_wr_valid, 1'b0);
        checkOutput("reset_mem_wr_data", bus.mem_wr_data, 512'h0);
        checkOutput("reset_rx_full", bus.rx_full, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_err_cnt", err_cnt, 16'h0);
        reset = 1'b1;
        @(negedge clk);
        monEn = 1'b1;

        $display("[TB] directed read");
        hsBefore = hsCount;
        sendMessage(16'h4000, 64'h1, 64'hABCD, '0, 64);
        drain();
        checkOutput("read_chunk_count", hsCount - hsBefore, N_CHUNKS);
        checkOutput("read_first_chunk", firstChunk, 64'hC000_0000_0000_001E);
        checkOutput("read_last_chunk", lastChunk, 64'h00AB_CDFF_FFFF_FF1E);

        $display("[TB] directed write");
        for (int w = 0; w < 16; w++) p[w*32 +: 32] = $urandom;
        wrBefore = wrCount;
        sendMessage(16'h8000, {$urandom, $urandom}, 64'h10, p, 64);
        drain();
        checkOutput("write_pulse_count", wrCount - wrBefore, 1);

        $display("[TB] invalid opcode then read");
        hsBefore = hsCount;
        sendMessage(16'h0000, 64'h0, 64'h0, '0, 64);
        sendMessage(16'h4123, 64'h5, 64'h9, '0, 0);
        drain();
        checkOutput("invalid_err_cnt", err_cnt, 16'd1);
        checkOutput("invalid_chunk_count", hsCount - hsBefore, N_CHUNKS);

        $display("[TB] src==dst then read");
        hsBefore = hsCount;
        sendMessage(16'h4000, 64'h7, 64'h7, '0, 0);
        sendMessage(16'h7fff, 64'h1234, 64'h5678, '0, 0);
        drain();
        checkOutput("sameaddr_err_cnt", err_cnt, 16'd2);
        checkOutput("sameaddr_chunk_count", hsCount - hsBefore, N_CHUNKS);

        $display("[TB] toggling memq_ready");
        readyMode = 1;
        hsBefore  = hsCount;
        sendMessage(16'h4abc, {$urandom, $urandom}, {$urandom, $urandom}, '0, 0);
        drain();
        checkOutput("toggle_chunk_count", hsCount - hsBefore, N_CHUNKS);

        $display("[TB] random messages");
        for (int m = 0; m < 40; m++) begin
            sel = $urandom_range(0, 9);
            hdr = 16'($urandom);
            if (sel < 4)       hdr[15:14] = 2'b01;
            else if (sel < 8)  hdr[15:14] = 2'b10;
            else if (sel == 8) hdr[15:14] = 2'b00;
            else               hdr[15:14] = 2'b11;
            s = {$urandom, $urandom};
            d = ($urandom_range(0, 6) == 0) ? s : {$urandom, $urandom};
            for (int w = 0; w < 16; w++) p[w*32 +: 32] = $urandom;
            readyMode = $urandom_range(1, 3);
            sendMessage(hdr, s, d, p, 0);
            if (m % 8 == 7) begin
                drain();
                checkOutput("random_err_cnt", err_cnt, 16'(expErr));
            end
        end

        $display("[TB] FIFO overflow during stalled reply, then reset");
        readyMode = 0;
        @(negedge clk);
        sendMessage(16'h4321, 64'h11, 64'h22, '0, 64);
        guard = 0;
        while (!bus.memq_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_reply_start actual=memq_valid_low required=memq_valid_high");
        end
        dropsBefore = dropCount;
        for (int k = 0; k <= FIFO_DEPTH; k++) begin
            bus.rx_ipg_data = {$urandom, $urandom};
            bus.rx_len      = 7'd64;
            bus.rx_valid    = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.rx_len   = '0;
        checkOutput("overflow_rx_full", bus.rx_full, 1'b1);
        @(negedge clk);
        checkOutput("overflow_drop_pulses", dropCount - dropsBefore, 1);
        checkOutput("overflow_busy", busy, 1'b1);
        #2;
        monEn = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midreset_memq_valid", bus.memq_valid, 1'b0);
        checkOutput("midreset_memq_data", bus.memq_data, 64'h0);
        checkOutput("midreset_mem_wr_valid", bus.mem_wr_valid, 1'b0);
        checkOutput("midreset_rx_full", bus.rx_full, 1'b0);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_err_cnt", err_cnt, 16'h0);
        expQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        expErr    = 0;
        readyMode = 2;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        monEn    = 1'b1;
        hsBefore = hsCount;
        sendMessage(16'h5a5a, 64'h3, 64'h4, '0, 0);
        drain();
        checkOutput("postreset_chunk_count", hsCount - hsBefore, N_CHUNKS);
        checkOutput("postreset_err_cnt", err_cnt, 16'h0);
        checkOutput("postreset_rx_full", bus.rx_full, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
